alu_rr_arbiter: RTL and testbench

- Shares the single 4-bit signed combinational `alu` datapath among N_REQ independent requesters.
- Round-robin arbitration; valid/ready handshake on the request side; registered, held response tagged with the requester ID.
- Sits between the operation sources (sequencers and test drivers) and the one `alu` instance.
- Gives one result at a time, with the ID for routing back.

---
 rtl/alu_arb_pkg.sv | 35 +++
 rtl/alu.sv | 22 ++
 rtl/rr_pick.sv | 30 +++
 rtl/alu_rr_arbiter.sv | 116 +++++++++++
 tb/tb_alu_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the round-robin ALU arbiter.
// Opcodes match the shared `alu` datapath; states are 2-bit encoded.
package alu_arb_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    ALU_OP_ADD = 2'b00,
    ALU_OP_SUB = 2'b01,
    ALU_OP_AND = 2'b10,
    ALU_OP_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } arb_state_e;

  // Signed overflow of an add/sub; logic ops never overflow.
  function automatic logic alu_ovf(input logic [ALU_W-1:0] a,
                                   input logic [ALU_W-1:0] b,
                                   input logic [ALU_W-1:0] res,
                                   input logic [1:0]       op);
    logic ovf;
    ovf = 1'b0;
    case (op)
      ALU_OP_ADD: ovf = (a[ALU_W-1] == b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
      ALU_OP_SUB: ovf = (a[ALU_W-1] != b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
      default:    ovf = 1'b0;
    endcase
    return ovf;
  endfunction

endpackage

// File: rtl/alu.sv
// Shared 4-bit signed combinational ALU: 00 add, 01 sub, 10 and, 11 or.
// Arithmetic wraps silently in two's complement.
module alu (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  input  logic        [1:0] ctrl,
  output logic signed [3:0] out
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    out = '0;
    case (ctrl)
      2'b00:   out = a + b;
      2'b01:   out = a - b;
      2'b10:   out = a & b;
      2'b11:   out = a | b;
      default: out = '0;
    endcase
  end

endmodule

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from last+1,
// wrapping modulo N_REQ. Purely combinational.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   winner,
  output logic             any
);

  always_comb begin
    int idx;
    grant  = '0;
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last) + k) % N_REQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        winner      = IDW'(idx);
        grant[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one `alu` among N_REQ requesters, with a held,
// ID-tagged response. Define ALU_ARB_OVF_EN to add the rsp_ovf output.
module alu_rr_arbiter
  import alu_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [ALU_W*N_REQ-1:0] req_a,
  input  logic [ALU_W*N_REQ-1:0] req_b,
  input  logic [2*N_REQ-1:0]     req_ctrl,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [ALU_W-1:0]       rsp_out,
`ifdef ALU_ARB_OVF_EN
  output logic                   rsp_ovf,
`endif
  output logic                   busy
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   last_q;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   winner;
  logic             any;
  logic             transfer;

  logic [ALU_W-1:0] a_q, b_q;
  logic [1:0]       ctrl_q;
  logic [IDW-1:0]   id_q;
  logic [ALU_W-1:0] alu_out;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req    (req_valid),
    .last   (last_q),
    .grant  (grant),
    .winner (winner),
    .any    (any)
  );

  alu u_alu (
    .a    (a_q),
    .b    (b_q),
    .ctrl (ctrl_q),
    .out  (alu_out)
  );

  // Grants are suppressed while reset is asserted so nothing is accepted then.
  assign transfer = (state_q == ST_IDLE) && rst_n && any;

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    busy      = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (rst_n) req_ready = grant;
        if (any)   state_d   = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= IDW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      if (transfer) last_q <= winner;
    end
  end

  // NOTE: operand/ID holding registers carry no reset; they are only read after a transfer loads them.
  always_ff @(posedge clk) begin
    if (transfer) begin
      a_q    <= req_a[winner*ALU_W +: ALU_W];
      b_q    <= req_b[winner*ALU_W +: ALU_W];
      ctrl_q <= req_ctrl[winner*2 +: 2];
      id_q   <= winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= '0;
`ifdef ALU_ARB_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EXEC: begin
          rsp_valid <= 1'b1;
          rsp_out   <= alu_out;
          rsp_id    <= id_q;
`ifdef ALU_ARB_OVF_EN
          rsp_ovf   <= alu_ovf(a_q, b_q, alu_out, ctrl_q);
`endif
        end
        ST_RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed self-checking bench for alu_rr_arbiter (N_REQ=4).
// Checks rsp_ovf as well when built with ALU_ARB_OVF_EN.
module tb_alu_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_ctrl;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_out;
  logic        busy;
`ifdef ALU_ARB_OVF_EN
  logic        rsp_ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctrl  (req_ctrl),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out),
`ifdef ALU_ARB_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] c);
    req_a[4*i +: 4]    = a;
    req_b[4*i +: 4]    = b;
    req_ctrl[2*i +: 2] = c;
  endtask

  // One isolated op from requester i; the arbiter must be idle on entry.
  task automatic do_op(input int i, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] c, input logic [3:0] exp_out,
                       input logic exp_ovf, input string name);
    logic [3:0] exp_rdy;
    exp_rdy = 4'b0001 << i;
    set_req(i, a, b, c);
    req_valid = exp_rdy;
    #1;
    n_checks++;
    if (req_ready !== exp_rdy) $display("FAIL %s req_ready got %b want %b", name, req_ready, exp_rdy);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1) $display("FAIL %s rsp_valid got %b want 1", name, rsp_valid);
    else n_pass++;
    n_checks++;
    if (rsp_out !== exp_out) $display("FAIL %s rsp_out got %b want %b", name, rsp_out, exp_out);
    else n_pass++;
    n_checks++;
    if (rsp_id !== 2'(i)) $display("FAIL %s rsp_id got %0d want %0d", name, rsp_id, i);
    else n_pass++;
`ifdef ALU_ARB_OVF_EN
    n_checks++;
    if (rsp_ovf !== exp_ovf) $display("FAIL %s rsp_ovf got %b want %b", name, rsp_ovf, exp_ovf);
    else n_pass++;
`else
    if (exp_ovf === 1'bx) $display("unexpected x on ovf expectation in %s", name);
`endif
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL %s rsp_valid after consume got %b want 0", name, rsp_valid);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_ctrl  = '0;
    tick();
    tick();
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL reset req_ready got %b want 0000", req_ready);
    else n_pass++;
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got %b want 0", rsp_valid);
    else n_pass++;
    n_checks++;
    if (rsp_id !== 2'd0 || rsp_out !== 4'd0) $display("FAIL reset rsp_id/out got %0d/%b want 0/0000", rsp_id, rsp_out);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL reset busy got %b want 0", busy);
    else n_pass++;
    req_valid = '0;
    rst_n     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 4'b0011, 4'b0010, 2'b00);
    req_valid = 4'b0001;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL single req_ready got %b want 0001", req_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) $display("FAIL single exec rsp_valid/busy got %b/%b want 0/1", rsp_valid, busy);
    else n_pass++;
    n_checks++;
    if (req_ready !== 4'b0000) $display("FAIL single exec req_ready got %b want 0000", req_ready);
    else n_pass++;
    req_valid = '0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 4'b0101 || rsp_id !== 2'd0)
      $display("FAIL single rsp got v=%b out=%b id=%0d want v=1 out=0101 id=0", rsp_valid, rsp_out, rsp_id);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single consume rsp_valid/busy got %b/%b want 0/0", rsp_valid, busy);
    else n_pass++;
  endtask

  task automatic test_wrap_sub();
    do_op(1, 4'b0111, 4'b0001, 2'b00, 4'b1000, 1'b1, "wrap_add");
    do_op(2, 4'b1000, 4'b0001, 2'b01, 4'b0111, 1'b1, "wrap_sub");
    do_op(1, 4'b0011, 4'b0010, 2'b00, 4'b0101, 1'b0, "add_no_ovf");
  endtask

  task automatic test_logic_ops();
    do_op(3, 4'b1100, 4'b1010, 2'b10, 4'b1000, 1'b0, "and_op");
    do_op(3, 4'b1100, 4'b1010, 2'b11, 4'b1110, 1'b0, "or_op");
  endtask

  task automatic test_round_robin();
    int exp_id;
    int cycles;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 4'b0001, 2'b00);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_id = g % 4;
      cycles = 0;
      while (rsp_valid !== 1'b1 && cycles < 10) begin
        tick();
        cycles++;
      end
      n_checks++;
      if (rsp_valid !== 1'b1) $display("FAIL rr timeout waiting for grant %0d", g);
      else n_pass++;
      n_checks++;
      if (rsp_id !== 2'(exp_id) || rsp_out !== 4'(exp_id + 1))
        $display("FAIL rr grant %0d got id=%0d out=%b want id=%0d out=%b", g, rsp_id, rsp_out, exp_id, 4'(exp_id + 1));
      else n_pass++;
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    // Pointer is at 0 after the round-robin run, so requester 1 wins first.
    set_req(1, 4'b0101, 4'b0001, 2'b01);
    set_req(2, 4'b0010, 4'b0011, 2'b00);
    req_valid = 4'b0110;
    #1;
    n_checks++;
    if (req_ready !== 4'b0010) $display("FAIL bp first req_ready got %b want 0010", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b0100;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_out !== 4'b0100 || rsp_id !== 2'd1 || req_ready !== 4'b0000)
        $display("FAIL bp hold cycle %0d got v=%b out=%b id=%0d rdy=%b want v=1 out=0100 id=1 rdy=0000",
                 c, rsp_valid, rsp_out, rsp_id, req_ready);
      else n_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) $display("FAIL bp release got v=%b rdy=%b want v=0 rdy=0100", rsp_valid, req_ready);
    else n_pass++;
    tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_out !== 4'b0101)
      $display("FAIL bp second got v=%b id=%0d out=%b want v=1 id=2 out=0101", rsp_valid, rsp_id, rsp_out);
    else n_pass++;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    set_req(0, 4'b0001, 4'b0001, 2'b00);
    set_req(1, 4'b0010, 4'b0010, 2'b00);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000)
      $display("FAIL rst_exec got v=%b busy=%b rdy=%b want v=0 busy=0 rdy=0000", rsp_valid, busy, req_ready);
    else n_pass++;
    rst_n     = 1'b1;
    req_valid = 4'b0011;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) $display("FAIL rst_exec pointer req_ready got %b want 0001", req_ready);
    else n_pass++;
    tick();
    req_valid = 4'b0010;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_out !== 4'b0010)
      $display("FAIL rst_exec rsp got v=%b id=%0d out=%b want v=1 id=0 out=0010", rsp_valid, rsp_id, rsp_out);
    else n_pass++;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap_sub();
    test_logic_ops();
    test_round_robin();
    test_backpressure();
    test_reset_exec();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
